// File: rtl/spi_controller_if.sv
// Command handshake, status and SPI pin bundle for spi_controller.
// master: command issuer / pin observer; slave: the controller itself.
interface spi_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       busy;
  logic       done;
  logic       ncs;
  logic       sclk;
  logic       copi;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data,
    input  cmd_ready, busy, done, ncs, sclk, copi
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data,
    output cmd_ready, busy, done, ncs, sclk, copi
  );
endinterface

// File: rtl/spi_controller.sv
// Write-only SPI mode-0 initiator: one 16-bit frame {data, addr, rw} per accepted
// command, shifted bit 0 first, with programmable sclk rate and ncs setup/hold/idle.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic           clk,
  input  logic           rst,
  spi_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
        busy_d = 1'b0;
        if (bus.cmd_valid && ready_q) begin
          shreg_d = {bus.cmd_data, bus.cmd_addr, bus.cmd_rw};
          copi_d  = bus.cmd_rw;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end else begin
          ready_d = 1'b1;
        end
      end
      SETUP: begin
        if (div_q == SETUP_LAST) begin
          div_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Data only moves on the falling edge, so it is stable across each rise.
          if (sclk_q) begin
            if (bit_q == 4'hF) begin
              copi_d  = 1'b0;
              state_d = HOLD;
            end else begin
              bit_d  = bit_q + 4'd1;
              copi_d = shreg_q[bit_q + 4'd1];
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (div_q == HOLD_LAST) begin
          div_d   = '0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          state_d = GAP;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (div_q == IDLE_LAST) begin
          div_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Frame payload is pure data; it is always reloaded before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ncs       = ncs_q;
  assign bus.sclk      = sclk_q;
  assign bus.copi      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: table-driven and random commands checked against a
// pin-level SPI sampler and a frame/timing model derived from the parameters.
`timescale 1ns/1ps
module tb_spi_controller;
  localparam int CLK_DIV    = 4;
  localparam int CS_SETUP   = 2;
  localparam int CS_HOLD    = 2;
  localparam int CS_IDLE    = 4;
  localparam int LOW_LEN    = CS_SETUP + 32 * CLK_DIV + CS_HOLD;
  localparam int FIRST_RISE = CS_SETUP + CLK_DIV;
  localparam int GAP_LEN    = CS_IDLE + 1;
  localparam int NVEC       = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_controller_if bus();

  spi_controller #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] bits;
    int          rises;
    int          low;
    int          first;
    logic        done_at_rise;
    int          gap;
  } frame_t;

  typedef struct {
    logic [15:0] frame;
    int          gap;
  } exp_t;

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] frame;
  } vec_t;

  frame_t mon_q[$];
  exp_t   exp_q[$];
  int n_checks  = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  int sclk_bad  = 0;
  int cur_rises = 0;

  function automatic logic [15:0] frame_of(input logic rw, input logic [6:0] a, input logic [7:0] d);
    return 16'(int'(d) * 256 + int'(a) * 2 + int'(rw));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pin-level sampler: rebuilds each frame from copi at sclk rises.
  initial begin : monitor
    logic   prev_ncs, prev_sclk, in_frame, have_prev;
    int     hi_run;
    frame_t cur;
    prev_ncs = 1'b1; prev_sclk = 1'b0; in_frame = 1'b0; have_prev = 1'b0; hi_run = 0;
    cur = '{bits: '0, rises: 0, low: 0, first: -1, done_at_rise: 1'b0, gap: -1};
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0; have_prev = 1'b0; hi_run = 0;
        prev_ncs = 1'b1; prev_sclk = 1'b0; cur_rises = 0;
      end else begin
        if (!bus.ncs) begin
          if (prev_ncs) begin
            cur.bits = '0; cur.rises = 0; cur.low = 0; cur.first = -1;
            cur.gap = have_prev ? hi_run : -1;
            in_frame = 1'b1;
            cur_rises = 0;
          end
          if (bus.sclk && !prev_sclk) begin
            if (cur.rises < 16) cur.bits[cur.rises[3:0]] = bus.copi;
            if (cur.rises == 0) cur.first = cur.low;
            cur.rises++;
            cur_rises = cur.rises;
          end
          cur.low++;
        end else begin
          if (!prev_ncs && in_frame) begin
            cur.done_at_rise = bus.done;
            mon_q.push_back(cur);
            in_frame = 1'b0; have_prev = 1'b1; hi_run = 0;
          end
          if (bus.sclk != prev_sclk) sclk_bad++;
          hi_run++;
        end
        if (bus.done) done_cnt++;
        prev_ncs = bus.ncs;
        prev_sclk = bus.sclk;
      end
    end
  end

  task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] d,
                       input logic [15:0] frame, input int gap, input bit keep);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_rw = rw; bus.cmd_addr = a; bus.cmd_data = d;
    for (int n = 0; n < 400 && bus.cmd_ready !== 1'b1; n++) @(negedge clk);
    chk("accept_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back('{frame: frame, gap: gap});
    @(negedge clk);
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    exp_t   e;
    frame_t m;
    for (int n = 0; n < 3000 && (mon_q.size() < exp_q.size() || bus.busy); n++) @(negedge clk);
    chk({tag, "_frame_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mon_q.pop_front();
      chk({tag, "_bits"}, 32'(m.bits), 32'(e.frame));
      chk({tag, "_rises"}, m.rises, 16);
      chk({tag, "_ncs_low"}, m.low, LOW_LEN);
      chk({tag, "_first_rise"}, m.first, FIRST_RISE);
      chk({tag, "_done_at_ncs_rise"}, 32'(m.done_at_rise), 32'd1);
      if (e.gap >= 0) chk({tag, "_ncs_gap"}, m.gap, e.gap);
    end
    exp_q.delete();
    mon_q.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t vecs[NVEC];
    int   d0;
    bit   keep, prev_keep;
    logic       rw;
    logic [6:0] a;
    logic [7:0] d;

    vecs[0] = '{rw: 1'b1, addr: 7'h02, data: 8'hA5, frame: 16'hA505};
    vecs[1] = '{rw: 1'b1, addr: 7'h04, data: 8'h80, frame: 16'h8009};
    vecs[2] = '{rw: 1'b1, addr: 7'h00, data: 8'hFF, frame: 16'hFF01};
    vecs[3] = '{rw: 1'b0, addr: 7'h7F, data: 8'h00, frame: 16'h00FE};
    vecs[4] = '{rw: 1'b1, addr: 7'h55, data: 8'hC3, frame: 16'hC3AB};

    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;

    // Reset values and first ready
    repeat (3) @(negedge clk);
    chk("rst_ncs", 32'(bus.ncs), 32'd1);
    chk("rst_sclk", 32'(bus.sclk), 32'd0);
    chk("rst_copi", 32'(bus.copi), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b0;
    #1 chk("ready_before_edge", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(bus.cmd_ready), 32'd1);

    // Table: single write first, then the rest back-to-back with valid held
    d0 = done_cnt;
    for (int i = 0; i < NVEC; i++)
      issue(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].frame,
            (i == 0) ? -1 : GAP_LEN, i < NVEC - 1);
    drain("table");
    chk("table_done_pulses", done_cnt - d0, NVEC);

    // Inputs changed mid-frame are ignored until the next accept
    issue(1'b1, 7'h02, 8'hA5, 16'hA505, -1, 1'b1);
    repeat (40) @(negedge clk);
    bus.cmd_data = 8'h3C;
    issue(1'b1, 7'h02, 8'h3C, 16'h3C05, GAP_LEN, 1'b0);
    drain("busy_change");

    // Asynchronous reset after the 7th sclk rise
    issue(1'b1, 7'h11, 8'h22, 16'h2223, -1, 1'b0);
    void'(exp_q.pop_back());
    for (int n = 0; n < 400 && cur_rises != 7; n++) @(negedge clk);
    chk("mid_rise7_reached", cur_rises, 7);
    d0 = done_cnt;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ncs", 32'(bus.ncs), 32'd1);
    chk("mid_rst_sclk", 32'(bus.sclk), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_no_frame", 32'(mon_q.size()), 32'd0);
    rst = 1'b0;
    issue(1'b1, 7'h01, 8'h5A, 16'h5A03, -1, 1'b0);
    drain("after_rst");

    // Random commands against the frame model
    prev_keep = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rw   = 1'($urandom_range(0, 1));
      a    = 7'($urandom);
      d    = 8'($urandom);
      keep = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(rw, a, d, frame_of(rw, a, d), prev_keep ? GAP_LEN : -1, keep);
      if (!keep) repeat ($urandom_range(0, 10)) @(negedge clk);
      prev_keep = keep;
    end
    drain("random");

    chk("sclk_toggle_while_ncs_high", sclk_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
